// File: rtl/fb_pixel_writer_if.sv
// Pixel request channel from the compute cores into the framebuffer writer.
// Valid/ready handshake carrying an (x, y) coordinate and an RGB565 colour.
interface fb_pixel_writer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [15:0] pix_rgb;

  modport master (
    output pix_valid, pix_x, pix_y, pix_rgb,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_rgb,
    output pix_ready
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// Buffers (x, y, rgb565) pixel writes and turns each into a byte-enabled
// single-beat 64-bit DDRAM write; also blanks the whole framebuffer on request.
module fb_pixel_writer #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          WIDTH      = 1920,
  parameter int          HEIGHT     = 1080,
  parameter int          LINE_WORDS = 512,
  parameter logic [28:0] BASE_WORD  = 29'h4000000
) (
  input  logic               clk,
  input  logic               reset_n,
  fb_pixel_writer_if.slave   pix,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic               drop_pulse,
  input  logic               ddram_busy,
  output logic               ddram_we,
  output logic [28:0]        ddram_addr,
  output logic [63:0]        ddram_din,
  output logic [7:0]         ddram_be,
  output logic [7:0]         ddram_burstcnt,
  output logic               ddram_rd
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LSH       = $clog2(LINE_WORDS);
  localparam int CLR_WORDS = HEIGHT * LINE_WORDS;
  localparam int CW        = $clog2(CLR_WORDS);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WORDS - 1);

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] rgb;
  } pix_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_t;

  pix_t          mem [FIFO_DEPTH];
  pix_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          fire;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          start_clr;
  logic          accept;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          pend;
  logic          pend_n;
  logic          busy_n;
  logic          we_n;
  logic [28:0]   addr_n;
  logic [63:0]   din_n;
  logic [7:0]    be_n;

  assign full           = (count == (AW+1)'(FIFO_DEPTH));
  assign empty          = (count == '0);
  assign pix.pix_ready  = !full;
  assign fire           = pix.pix_valid && !full;
  assign in_range       = ({1'b0, pix.pix_x} < 12'(WIDTH)) &&
                          ({1'b0, pix.pix_y} < 12'(HEIGHT));
  assign push           = fire && in_range;
  assign head           = mem[rd_ptr];
  assign accept         = ddram_we && !ddram_busy;
  assign ddram_burstcnt = 8'd1;
  assign ddram_rd       = 1'b0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pix.pix_x, pix.pix_y, pix.pix_rgb};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count + (AW+1)'(push) - (AW+1)'(pop);
      drop_pulse <= fire && !in_range;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_n    = pend;
    busy_n    = clear_busy;
    we_n      = ddram_we;
    addr_n    = ddram_addr;
    din_n     = ddram_din;
    be_n      = ddram_be;
    pop       = 1'b0;
    start_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_req)   start_clr = 1'b1;
        else if (!empty) pop       = 1'b1;
      end
      WRITE: begin
        if (clear_req) pend_n = 1'b1;
        if (accept) begin
          if (pend || clear_req) start_clr = 1'b1;
          else if (!empty)       pop       = 1'b1;
          else begin
            we_n    = 1'b0;
            state_n = IDLE;
          end
        end
      end
      CLEAR: begin
        if (clear_req) pend_n = 1'b1;
        if (accept) begin
          if (pend || clear_req) begin
            cnt_n  = '0;
            pend_n = 1'b0;
          end else if (cnt == CLR_LAST) begin
            we_n    = 1'b0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
          addr_n = BASE_WORD + 29'(cnt_n);
        end
      end
      default: state_n = IDLE;
    endcase
    // A pending clear always wins over draining the FIFO.
    if (start_clr) begin
      state_n = CLEAR;
      cnt_n   = '0;
      pend_n  = 1'b0;
      busy_n  = 1'b1;
      we_n    = 1'b1;
      addr_n  = BASE_WORD;
      din_n   = '0;
      be_n    = 8'hFF;
    end else if (pop) begin
      state_n = WRITE;
      we_n    = 1'b1;
      addr_n  = BASE_WORD + (29'(head.y) << LSH) + 29'(head.x[10:2]);
      din_n   = {4{head.rgb}};
      be_n    = 8'b11 << {head.x[1:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      clear_busy <= 1'b0;
      ddram_we   <= 1'b0;
      ddram_addr <= '0;
      ddram_din  <= '0;
      ddram_be   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      clear_busy <= busy_n;
      ddram_we   <= we_n;
      ddram_addr <= addr_n;
      ddram_din  <= din_n;
      ddram_be   <= be_n;
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: directed and random pixel traffic against a
// coordinate-to-beat reference model, plus a short-frame clear instance.
module tb_fb_pixel_writer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  fb_pixel_writer_if pa ();
  fb_pixel_writer_if pb ();

  logic        clear_a = 1'b0, busy_a = 1'b0;
  logic        cbusy_a, drop_a, we_a, rd_a;
  logic [28:0] addr_a;
  logic [63:0] din_a;
  logic [7:0]  be_a, bc_a;

  logic        clear_b = 1'b0, busy_b = 1'b0;
  logic        cbusy_b, drop_b, we_b, rd_b;
  logic [28:0] addr_b;
  logic [63:0] din_b;
  logic [7:0]  be_b, bc_b;

  fb_pixel_writer u_dut (
    .clk(clk), .reset_n(reset_n), .pix(pa),
    .clear_req(clear_a), .clear_busy(cbusy_a), .drop_pulse(drop_a),
    .ddram_busy(busy_a), .ddram_we(we_a), .ddram_addr(addr_a),
    .ddram_din(din_a), .ddram_be(be_a), .ddram_burstcnt(bc_a),
    .ddram_rd(rd_a)
  );

  // Two-line frame so a full clear fits in a short run.
  fb_pixel_writer #(.HEIGHT(2)) u_clr (
    .clk(clk), .reset_n(reset_n), .pix(pb),
    .clear_req(clear_b), .clear_busy(cbusy_b), .drop_pulse(drop_b),
    .ddram_busy(busy_b), .ddram_we(we_b), .ddram_addr(addr_b),
    .ddram_din(din_b), .ddram_be(be_b), .ddram_burstcnt(bc_b),
    .ddram_rd(rd_b)
  );

  typedef struct {
    logic [28:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
    int          c;
  } beat_t;

  beat_t mon_q[$];
  beat_t exp_q[$];
  beat_t b_q[$];
  int drops_seen = 0;
  int exp_drops = 0;
  int last_push_cyc = 0;
  int clr_n = 0;
  int clr_err = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : mon_a
    logic hold;
    logic [28:0] h_addr;
    logic [63:0] h_din;
    logic [7:0]  h_be;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) hold = 1'b0;
      else begin
        if (hold) begin
          check("hold_addr", addr_a, h_addr);
          check("hold_din", din_a, h_din);
          check("hold_we_be", {we_a, be_a}, {1'b1, h_be});
        end
        if (we_a && !busy_a) mon_q.push_back('{addr_a, din_a, be_a, cyc});
        if (drop_a) drops_seen++;
        hold = we_a && busy_a;
        h_addr = addr_a;
        h_din = din_a;
        h_be = be_a;
      end
    end
  end

  initial begin : mon_b
    logic chk_fall;
    chk_fall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (chk_fall) begin
          chk_fall = 1'b0;
          check("clear_busy_fall", cbusy_b, 1'b0);
        end
        if (we_b && !busy_b) begin
          if (clr_n < 1024) begin
            if (addr_b !== 29'(32'h4000000 + clr_n) || be_b !== 8'hFF ||
                din_b !== 64'd0 || cbusy_b !== 1'b1) clr_err++;
            clr_n++;
            if (clr_n == 1024) chk_fall = 1'b1;
          end else begin
            b_q.push_back('{addr_b, din_b, be_b, cyc});
          end
        end
      end
    end
  end

  task automatic push_a(input logic [10:0] x, input logic [10:0] y,
                        input logic [15:0] rgb, output int waited);
    int a;
    beat_t e;
    waited = 0;
    pa.pix_valid = 1'b1;
    pa.pix_x = x;
    pa.pix_y = y;
    pa.pix_rgb = rgb;
    forever begin
      @(negedge clk);
      if (pa.pix_ready || waited >= 200) break;
      waited++;
      @(posedge clk);
      #1 busy_a = 1'b0;
    end
    last_push_cyc = cyc;
    if (waited >= 200) check("push_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 pa.pix_valid = 1'b0;
    if (waited < 200) begin
      if (x < 11'd1920 && y < 11'd1080) begin
        a = 'h4000000 + int'(y) * 512 + int'(x) / 4;
        e.addr = 29'(a);
        e.din = {rgb, rgb, rgb, rgb};
        e.be = 8'(3 << (2 * (int'(x) % 4)));
        e.c = last_push_cyc;
        exp_q.push_back(e);
      end else begin
        exp_drops++;
      end
    end
  endtask

  task automatic push_b(input logic [10:0] x, input logic [10:0] y,
                        input logic [15:0] rgb);
    pb.pix_valid = 1'b1;
    pb.pix_x = x;
    pb.pix_y = y;
    pb.pix_rgb = rgb;
    @(negedge clk);
    check("b_ready", pb.pix_ready, 1'b1);
    @(posedge clk);
    #1 pb.pix_valid = 1'b0;
  endtask

  task automatic lat_check(input string tag);
    int t = 0;
    while (mon_q.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (mon_q.size() == 0) check({tag, "_timeout"}, 1'b0, 1'b1);
    else if (exp_q.size() > 0)
      check(tag, 64'(mon_q[0].c - exp_q[0].c), 64'd2);
  endtask

  task automatic drain_compare(input string tag);
    int t = 0;
    beat_t e, m;
    while (mon_q.size() < exp_q.size() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check({tag, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mon_q.pop_front();
      check({tag, "_addr"}, m.addr, e.addr);
      check({tag, "_din"}, m.din, e.din);
      check({tag, "_be"}, m.be, e.be);
    end
    check({tag, "_drops"}, 64'(drops_seen), 64'(exp_drops));
    mon_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int w;
    int t;
    beat_t m;
    pa.pix_valid = 1'b0;
    pa.pix_x = '0;
    pa.pix_y = '0;
    pa.pix_rgb = '0;
    pb.pix_valid = 1'b0;
    pb.pix_x = '0;
    pb.pix_y = '0;
    pb.pix_rgb = '0;

    #12;
    check("rst_we", we_a, 1'b0);
    check("rst_addr", addr_a, 29'd0);
    check("rst_din", din_a, 64'd0);
    check("rst_be", be_a, 8'd0);
    check("rst_clear_busy", cbusy_a, 1'b0);
    check("rst_drop", drop_a, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", pa.pix_ready, 1'b1);
    check("burstcnt", bc_a, 8'd1);
    check("rd", rd_a, 1'b0);

    push_a(11'd0, 11'd0, 16'hF800, w);
    lat_check("lat_first");
    drain_compare("origin");

    push_a(11'd1919, 11'd1079, 16'h07E0, w);
    drain_compare("corner");

    push_a(11'd1920, 11'd5, 16'h1111, w);
    check("drop_x_ready", 64'(w), 64'd0);
    push_a(11'd3, 11'd1080, 16'h2222, w);
    check("drop_y_ready", 64'(w), 64'd0);
    drain_compare("drops");

    for (int i = 0; i < 40; i++) begin
      busy_a = ($urandom_range(0, 2) == 0);
      push_a(11'($urandom_range(0, 1999)), 11'($urandom_range(0, 1099)),
             16'($urandom), w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    busy_a = 1'b0;
    drain_compare("rand");

    busy_a = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_a(11'(i * 113), 11'(i * 7), 16'(i * 16'h0F0F + 1), w);
      check("burst_no_wait", 64'(w), 64'd0);
    end
    @(negedge clk);
    check("burst_ready_low", pa.pix_ready, 1'b0);
    check("burst_we_held", we_a, 1'b1);
    check("burst_head_addr", addr_a, exp_q[0].addr);
    @(posedge clk);
    #1 busy_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("burst_ready_back", pa.pix_ready, 1'b1);
    @(posedge clk);
    #1;
    drain_compare("burst");

    clear_b = 1'b1;
    @(posedge clk);
    #1 clear_b = 1'b0;
    @(negedge clk);
    check("clear_busy_rise", cbusy_b, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    push_b(11'd5, 11'd1, 16'h1234);
    t = 0;
    while (b_q.size() == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("clear_beats", 64'(clr_n), 64'd1024);
    check("clear_errors", 64'(clr_err), 64'd0);
    check("clear_tail_count", 64'(b_q.size()), 64'd1);
    if (b_q.size() > 0) begin
      m = b_q.pop_front();
      check("clear_tail_addr", m.addr, 29'h4000201);
      check("clear_tail_be", m.be, 8'h0C);
      check("clear_tail_din", m.din, 64'h1234123412341234);
    end
    @(posedge clk);
    #1;

    busy_a = 1'b1;
    push_a(11'd10, 11'd20, 16'hAAAA, w);
    push_a(11'd11, 11'd20, 16'hBBBB, w);
    t = 0;
    while (!we_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_we_up", we_a, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_we_async", we_a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    busy_a = 1'b0;
    exp_q.delete();
    mon_q.delete();
    repeat (10) @(negedge clk);
    check("rst_mid_no_beats", 64'(mon_q.size()), 64'd0);
    check("rst_mid_ready", pa.pix_ready, 1'b1);
    check("rst_mid_we_low", we_a, 1'b0);
    @(posedge clk);
    #1;
    push_a(11'd7, 11'd7, 16'h5A5A, w);
    lat_check("lat_after_rst");
    drain_compare("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
